// File: rtl/mux_scan_ctrl_311_if.sv
// Signal bundle between the scan controller and its driver/observer.
// The slave side is the controller; the master side is the environment
// that requests scans and provides the mux output.
`timescale 1ns/1ps
interface mux_scan_ctrl_311_if;
  logic       start_311;
  logic [3:0] mask_311;
  logic       y_311;
  logic       s0_311;
  logic       s1_311;
  logic       busy_311;
  logic       done_311;
  logic [3:0] sample_311;

  modport slave (
    input  start_311, mask_311, y_311,
    output s0_311, s1_311, busy_311, done_311, sample_311
  );

  modport master (
    output start_311, mask_311, y_311,
    input  s0_311, s1_311, busy_311, done_311, sample_311
  );
endinterface

// File: rtl/mux_scan_ctrl_311.sv
// Select sequencer and sampler for a 4:1 mux. It walks the enabled channels
// in ascending order, holds each one for DWELL cycles, captures the mux
// output at the end of each dwell and pulses done when the scan completes.
`timescale 1ns/1ps
module mux_scan_ctrl_311 #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input logic                clk_311,
  input logic                rst_n_311,
  mux_scan_ctrl_311_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       mask_q;
  logic             busy;
  logic             done;
  logic [3:0]       sample;

  logic [1:0]       first_ch;
  logic             has_first;
  logic [1:0]       next_ch;
  logic             has_next;

  // Lowest enabled channel of the incoming mask, and the next enabled
  // channel above the current select in the latched mask.
  always_comb begin
    first_ch  = '0;
    has_first = 1'b0;
    next_ch   = '0;
    has_next  = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!has_first && bus.mask_311[k]) begin
        has_first = 1'b1;
        first_ch  = 2'(k);
      end
      if (!has_next && mask_q[k] && (k > 32'(sel))) begin
        has_next = 1'b1;
        next_ch  = 2'(k);
      end
    end
  end

  // Scan state machine with registered select, status and sample outputs.
  always_ff @(posedge clk_311 or negedge rst_n_311) begin
    if (!rst_n_311) begin
      state  <= S_IDLE;
      sel    <= '0;
      cnt    <= '0;
      mask_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sample <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_311) begin
            sample <= '0;
            if (has_first) begin
              mask_q <= bus.mask_311;
              sel    <= first_ch;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_DWELL;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DWELL: begin
          if (cnt == CNT_LAST) begin
            sample[sel] <= bus.y_311;
            cnt         <= '0;
            if (has_next) begin
              sel <= next_ch;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s0_311     = sel[0];
  assign bus.s1_311     = sel[1];
  assign bus.busy_311   = busy;
  assign bus.done_311   = done;
  assign bus.sample_311 = sample;

endmodule

// File: tb/tb_mux_scan_ctrl_311.sv
// Scoreboard bench for mux_scan_ctrl_311: two instances (dwell 4 and 1),
// each feeding a behavioural 4:1 mux. Stimulus pushes the expected per-cycle
// status of every scan; a monitor pops one entry per cycle and compares.
`timescale 1ns/1ps
module tb_mux_scan_ctrl_311;

  localparam int DW_A = 4;
  localparam int DW_B = 1;

  typedef struct {
    int         inst;
    logic       busy;
    logic       done;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       chk_sample;
  } win_t;

  logic clk;
  logic rst_n;
  logic [3:0] chv;

  int checks   = 0;
  int failures = 0;

  win_t       exp_q[$];
  logic [1:0] last_sel[2];

  mux_scan_ctrl_311_if ifa();
  mux_scan_ctrl_311_if ifb();

  mux_scan_ctrl_311 #(.DWELL(DW_A), .CNT_W(8)) dut_a (
    .clk_311   (clk),
    .rst_n_311 (rst_n),
    .bus       (ifa.slave)
  );

  mux_scan_ctrl_311 #(.DWELL(DW_B), .CNT_W(8)) dut_b (
    .clk_311   (clk),
    .rst_n_311 (rst_n),
    .bus       (ifb.slave)
  );

  // Behavioural 4:1 mux: chv bit k is input ik
  assign ifa.y_311 = chv[{ifa.s1_311, ifa.s0_311}];
  assign ifb.y_311 = chv[{ifb.s1_311, ifb.s0_311}];

  logic       busy_v[2];
  logic       done_v[2];
  logic [1:0] sel_v[2];
  logic [3:0] sample_v[2];

  assign busy_v[0]   = ifa.busy_311;
  assign busy_v[1]   = ifb.busy_311;
  assign done_v[0]   = ifa.done_311;
  assign done_v[1]   = ifb.done_311;
  assign sel_v[0]    = {ifa.s1_311, ifa.s0_311};
  assign sel_v[1]    = {ifb.s1_311, ifb.s0_311};
  assign sample_v[0] = ifa.sample_311;
  assign sample_v[1] = ifb.sample_311;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive(int inst, logic st, logic [3:0] m);
    if (inst == 0) begin
      ifa.start_311 = st;
      ifa.mask_311  = m;
    end else begin
      ifb.start_311 = st;
      ifb.mask_311  = m;
    end
  endtask

  // Reference model: each enabled channel, lowest first, is selected for
  // dwell cycles; then one done cycle with sample = enabled inputs only.
  task automatic push_scan(int inst, logic [3:0] m, output int n);
    int   d;
    win_t w;
    d = (inst == 0) ? DW_A : DW_B;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        n++;
        for (int r = 0; r < d; r++) begin
          w.inst = inst; w.busy = 1'b1; w.done = 1'b0; w.sel = 2'(k);
          w.sample = '0; w.chk_sample = 1'b0;
          exp_q.push_back(w);
        end
        last_sel[inst] = 2'(k);
      end
    end
    w.inst = inst; w.busy = 1'b0; w.done = 1'b1; w.sel = last_sel[inst];
    w.sample = m & chv; w.chk_sample = 1'b1;
    exp_q.push_back(w);
  endtask

  task automatic check_reset_vals(int inst);
    check("rst_busy",   32'(busy_v[inst]),   0);
    check("rst_done",   32'(done_v[inst]),   0);
    check("rst_sel",    32'(sel_v[inst]),    0);
    check("rst_sample", 32'(sample_v[inst]), 0);
  endtask

  // Called at posedge+2. hold keeps start high into the next scan, disturb
  // pulses start and scrambles the mask during the second dwell, abort_at>0
  // asserts reset asynchronously after that many cycles.
  task automatic scan(int inst, logic [3:0] m, bit hold, bit disturb, int abort_at);
    int n;
    int d;
    d = (inst == 0) ? DW_A : DW_B;
    drive(inst, 1'b1, m);
    @(posedge clk); #2;
    push_scan(inst, m, n);
    if (!hold) drive(inst, 1'b0, m);
    for (int c = 1; c <= n * d + 1; c++) begin
      @(posedge clk); #2;
      if (disturb && c == d) drive(inst, 1'b1, 4'($urandom_range(0, 15)));
      if (disturb && c == d + 1) drive(inst, 1'b0, m);
      if (abort_at != 0 && c == abort_at) begin
        #1 rst_n = 1'b0;
        exp_q.delete();
        last_sel[0] = '0;
        last_sel[1] = '0;
        #1 check_reset_vals(inst);
        #3 rst_n = 1'b1;
        drive(inst, 1'b0, m);
        @(posedge clk); #2;
        return;
      end
    end
  endtask

  // Monitor: one scoreboard entry per cycle while a scan is expected,
  // otherwise both instances must be idle.
  initial begin
    win_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("busy", 32'(busy_v[e.inst]), 32'(e.busy));
          check("done", 32'(done_v[e.inst]), 32'(e.done));
          check("sel",  32'(sel_v[e.inst]),  32'(e.sel));
          if (e.chk_sample)
            check("sample", 32'(sample_v[e.inst]), 32'(e.sample));
          check("other_idle", 32'(busy_v[1 - e.inst] | done_v[1 - e.inst]), 0);
        end else begin
          for (int i = 0; i < 2; i++)
            check("idle", 32'(busy_v[i] | done_v[i]), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    rst_n = 1'b1;
    chv = '0;
    last_sel[0] = '0;
    last_sel[1] = '0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;

    // full scan: i0..i3 = 1,0,1,0
    chv = 4'b0101;
    scan(0, 4'b1111, 1'b0, 1'b0, 0);
    // sparse mask: i0..i3 = 0,1,1,1
    chv = 4'b1110;
    scan(0, 4'b1010, 1'b0, 1'b0, 0);
    // zero mask clears sample and skips busy
    scan(0, 4'b0000, 1'b0, 1'b0, 0);
    // start and mask change during the scan are ignored
    chv = 4'($urandom_range(0, 15));
    scan(0, 4'b0111, 1'b0, 1'b1, 0);
    // reset during the second channel dwell
    chv = 4'b1111;
    scan(0, 4'b1111, 1'b0, 1'b0, DW_A + 1);
    chv = 4'b0011;
    scan(0, 4'b1011, 1'b0, 1'b0, 0);
    // random scans
    for (int i = 0; i < 8; i++) begin
      chv = 4'($urandom_range(0, 15));
      m   = 4'($urandom_range(0, 15));
      scan(0, m, 1'b0, (m == 4'b1111) ? 1'b1 : 1'b0, 0);
    end
    // dwell of one, back-to-back with start held high
    for (int i = 0; i < 6; i++) begin
      chv = 4'($urandom_range(0, 15));
      m   = (i == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      scan(1, m, (i < 5) ? 1'b1 : 1'b0, 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
